// File: rtl/i2c_master_arb.sv
// i2c_master_arb
// Two-requester arbiter in front of a single I2C master. One command is
// accepted at a time from req0 or req1. It is forwarded to the master and
// held there until the master reports done, or until a cycle budget runs out.
// The result is then returned to the requester that owns the grant.
//
// Parameters
//   TIMEOUT_CYCLES : clk cycles allowed from ISSUE entry to master done
// Ports
//   clk, rst                      : system clock, synchronous active-high reset
//   reqN_valid/rw/addr/din        : command from requester N (sampled in IDLE only)
//   reqN_ready                    : one-cycle accept pulse (first ISSUE cycle)
//   reqN_done/ackErr/dout         : one-cycle completion with status and read data
//   gnt                           : one-hot current owner, 0 when idle
//   timeout                       : pulses with done when the command was aborted
//   m_dataValid/rw/addr/din       : command to the I2C master
//   m_busy/done/ackErr/dout       : status from the I2C master
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no owner; arbitrate and latch a pending command
// ISSUE     | m_dataValid high, waiting for the master to go busy
// WAIT_DONE | master running the transfer, waiting for m_done
// RESP      | one-cycle done pulse to the owner, release the grant
module i2c_master_arb #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rw,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_din,
    output logic       req0_ready,
    output logic       req0_done,
    output logic       req0_ackErr,
    output logic [7:0] req0_dout,
    input  logic       req1_valid,
    input  logic       req1_rw,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_din,
    output logic       req1_ready,
    output logic       req1_done,
    output logic       req1_ackErr,
    output logic [7:0] req1_dout,
    output logic [1:0] gnt,
    output logic       timeout,
    output logic       m_dataValid,
    output logic       m_rw,
    output logic [6:0] m_addr,
    output logic [7:0] m_din,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ackErr,
    input  logic [7:0] m_dout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    gnt_q, gnt_nx;
    logic [1:0]    ready_q, ready_nx;
    // 1 when req1 was served most recently, so req0 wins the next tie
    logic          last1_q, last1_nx;
    logic          rw_q, rw_nx;
    logic [6:0]    addr_q, addr_nx;
    logic [7:0]    din_q, din_nx;
    logic [7:0]    dout_q, dout_nx;
    logic          err_q, err_nx;
    logic          to_q, to_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic          pick0;
    logic          tmo_hit;
    logic          resp0, resp1;

    // The counter reads k during the k-th cycle after ISSUE entry, so leaving
    // at count TIMEOUT_CYCLES-1 puts RESP exactly TIMEOUT_CYCLES cycles later.
    assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Round robin: on a tie, take the requester that was not served last.
    assign pick0 = req0_valid & (~req1_valid | last1_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= 2'b00;
            ready_q <= 2'b00;
            last1_q <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= 7'h00;
            din_q   <= 8'h00;
            dout_q  <= 8'h00;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            gnt_q   <= gnt_nx;
            ready_q <= ready_nx;
            last1_q <= last1_nx;
            rw_q    <= rw_nx;
            addr_q  <= addr_nx;
            din_q   <= din_nx;
            dout_q  <= dout_nx;
            err_q   <= err_nx;
            to_q    <= to_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_q;
        ready_nx = 2'b00;
        last1_nx = last1_q;
        rw_nx    = rw_q;
        addr_nx  = addr_q;
        din_nx   = din_q;
        dout_nx  = dout_q;
        err_nx   = err_q;
        to_nx    = to_q;
        cnt_nx   = cnt_q;

        unique case (state)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    gnt_nx   = pick0 ? 2'b01 : 2'b10;
                    ready_nx = pick0 ? 2'b01 : 2'b10;
                    rw_nx    = pick0 ? req0_rw   : req1_rw;
                    addr_nx  = pick0 ? req0_addr : req1_addr;
                    din_nx   = pick0 ? req0_din  : req1_din;
                    cnt_nx   = '0;
                    state_nx = ISSUE;
                end
            end
            ISSUE, WAIT_DONE: begin
                cnt_nx = cnt_q + CW'(1);
                // A real completion beats an expiring budget in the same cycle.
                if (m_done) begin
                    dout_nx  = m_dout;
                    err_nx   = m_ackErr;
                    to_nx    = 1'b0;
                    state_nx = RESP;
                end else if (tmo_hit) begin
                    dout_nx  = 8'h00;
                    err_nx   = 1'b1;
                    to_nx    = 1'b1;
                    state_nx = RESP;
                end else if (state == ISSUE && m_busy) begin
                    state_nx = WAIT_DONE;
                end
            end
            RESP: begin
                last1_nx = gnt_q[1];
                gnt_nx   = 2'b00;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign resp0 = (state == RESP) & gnt_q[0];
    assign resp1 = (state == RESP) & gnt_q[1];

    assign m_dataValid = (state == ISSUE);
    assign m_rw        = rw_q;
    assign m_addr      = addr_q;
    assign m_din       = din_q;

    assign gnt         = gnt_q;
    assign timeout     = (state == RESP) & to_q;

    assign req0_ready  = ready_q[0];
    assign req0_done   = resp0;
    assign req0_ackErr = resp0 & err_q;
    assign req0_dout   = resp0 ? dout_q : 8'h00;

    assign req1_ready  = ready_q[1];
    assign req1_done   = resp1;
    assign req1_ackErr = resp1 & err_q;
    assign req1_dout   = resp1 ? dout_q : 8'h00;

endmodule

// File: tb/tb_i2c_master_arb.sv
// tb_i2c_master_arb
// Self-checking bench for i2c_master_arb. Expected transactions are queued in
// service order when stimulus is driven. A behavioural I2C master answers
// each issued command. A monitor pops the queue on every done pulse.
module tb_i2c_master_arb;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_rw, req1_valid, req1_rw;
    logic [6:0] req0_addr, req1_addr;
    logic [7:0] req0_din, req1_din;
    logic       req0_ready, req0_done, req0_ackErr;
    logic       req1_ready, req1_done, req1_ackErr;
    logic [7:0] req0_dout, req1_dout;
    logic [1:0] gnt;
    logic       timeout;
    logic       m_dataValid, m_rw;
    logic [6:0] m_addr;
    logic [7:0] m_din;
    logic       m_busy, m_done, m_ackErr;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    i2c_master_arb #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_din(req0_din), .req0_ready(req0_ready), .req0_done(req0_done),
        .req0_ackErr(req0_ackErr), .req0_dout(req0_dout),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_din(req1_din), .req1_ready(req1_ready), .req1_done(req1_done),
        .req1_ackErr(req1_ackErr), .req1_dout(req1_dout),
        .gnt(gnt), .timeout(timeout),
        .m_dataValid(m_dataValid), .m_rw(m_rw), .m_addr(m_addr), .m_din(m_din),
        .m_busy(m_busy), .m_done(m_done), .m_ackErr(m_ackErr), .m_dout(m_dout)
    );

    typedef struct {
        int         id;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] din;
        logic [7:0] dout;   // master response, and expected reqN_dout
        logic       err;
        logic       to;     // master never completes: expect abort
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   issue_cyc = 0;
    logic prev_dv = 1'b0;
    exp_t mcur;
    int   mph = 0;
    int   mk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push(input int id, input logic rw, input logic [6:0] addr,
                                 input logic [7:0] din, input logic [7:0] dout,
                                 input logic err, input logic to);
        exp_t e;
        e.id = id; e.rw = rw; e.addr = addr; e.din = din;
        e.dout = to ? 8'h00 : dout;
        e.err = to ? 1'b1 : err;
        e.to = to;
        sb.push_back(e);
    endfunction

    // Behavioural I2C master: busy two cycles after seeing a command, done
    // three cycles later, or stays busy forever for an abort scenario.
    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_ackErr = 1'b0; m_dout = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_ackErr = 1'b0; m_dout = 8'h00;
                mph = 0;
            end else begin
                case (mph)
                    0: begin
                        if (m_dataValid && sb.size() > 0) begin
                            mcur = sb[0];
                            mk = 0;
                            mph = 1;
                        end
                    end
                    1: begin
                        mk++;
                        if (mk == 2) begin m_busy = 1'b1; mk = 0; mph = 2; end
                    end
                    2: begin
                        mk++;
                        if (mcur.to) begin
                            if (req0_done || req1_done) begin m_busy = 1'b0; mph = 0; end
                        end else if (mk == 3) begin
                            m_busy = 1'b0; m_done = 1'b1;
                            m_dout = mcur.dout; m_ackErr = mcur.err;
                            mph = 3;
                        end
                    end
                    default: begin
                        m_done = 1'b0; m_dout = 8'h00; m_ackErr = 1'b0;
                        mph = 0;
                    end
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (m_dataValid && !prev_dv) begin
                    if (sb.size() == 0) check("unexpected_issue", 1, 0);
                    else begin
                        e = sb[0];
                        issue_cyc = cyc;
                        check("issue_gnt", gnt, (e.id == 0) ? 2'b01 : 2'b10);
                        check("issue_addr", m_addr, e.addr);
                        check("issue_rw", m_rw, e.rw);
                        check("issue_din", m_din, e.din);
                        check("issue_ready", (e.id == 0) ? req0_ready : req1_ready, 1);
                        check("other_ready", (e.id == 0) ? req1_ready : req0_ready, 0);
                    end
                end
                if (req0_done || req1_done) begin
                    if (sb.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("done_id", {req1_done, req0_done}, (e.id == 0) ? 2'b01 : 2'b10);
                        check("done_dout", (e.id == 0) ? req0_dout : req1_dout, e.dout);
                        check("done_ackerr", (e.id == 0) ? req0_ackErr : req1_ackErr, e.err);
                        check("done_timeout", timeout, e.to);
                        check("other_dout", (e.id == 0) ? req1_dout : req0_dout, 0);
                        check("other_ackerr", (e.id == 0) ? req1_ackErr : req0_ackErr, 0);
                        check("hold_addr", m_addr, e.addr);
                        if (e.to) check("timeout_latency", cyc - issue_cyc, TMO);
                    end
                end else if (timeout) begin
                    check("stray_timeout", timeout, 0);
                end
            end
            prev_dv = m_dataValid;
        end
    end

    task automatic wait_ready(input int id, input string tag);
        int k = 0;
        while (!((id == 0) ? req0_ready : req1_ready) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check({tag, "_ready_wait"}, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (sb.size() > 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            check({tag, "_done_wait"}, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input int id, input logic rw, input logic [6:0] addr,
                        input logic [7:0] din, input logic [7:0] dout,
                        input logic err, input logic to, input string tag);
        push(id, rw, addr, din, dout, err, to);
        if (id == 0) begin
            req0_rw = rw; req0_addr = addr; req0_din = din; req0_valid = 1'b1;
        end else begin
            req1_rw = rw; req1_addr = addr; req1_din = din; req1_valid = 1'b1;
        end
        @(negedge clk);
        wait_ready(id, tag);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        int k;
        rst = 1'b1;
        req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = 7'h00; req0_din = 8'h00;
        req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = 7'h00; req1_din = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_gnt", gnt, 0);
        check("rst_dv", m_dataValid, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);
        check("rst_done", {req1_done, req0_done}, 0);
        check("rst_ackerr", {req1_ackErr, req0_ackErr}, 0);
        check("rst_dout", {req1_dout, req0_dout}, 0);
        check("rst_timeout", timeout, 0);
        check("rst_maddr", m_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: req0 first, then strict alternation.
        push(0, 1'b1, 7'h12, 8'h00, 8'h3C, 1'b0, 1'b0);
        push(1, 1'b0, 7'h21, 8'h5A, 8'h00, 1'b0, 1'b0);
        push(0, 1'b1, 7'h12, 8'h00, 8'h3C, 1'b0, 1'b0);
        push(1, 1'b0, 7'h21, 8'h5A, 8'h00, 1'b0, 1'b0);
        req0_rw = 1'b1; req0_addr = 7'h12; req0_din = 8'h00;
        req1_rw = 1'b0; req1_addr = 7'h21; req1_din = 8'h5A;
        req0_valid = 1'b1; req1_valid = 1'b1;
        nr = 0; k = 0;
        while (nr < 4 && k < 400) begin
            @(negedge clk);
            k++;
            if (req0_ready || req1_ready) nr++;
        end
        if (nr < 4) check("contention_ready_count", nr, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("contention");

        send(0, 1'b1, 7'h55, 8'h00, 8'hA5, 1'b0, 1'b0, "single_read");
        wait_idle("single_read");

        send(1, 1'b0, 7'h50, 8'h2F, 8'h00, 1'b1, 1'b0, "nack");
        wait_idle("nack");

        send(0, 1'b1, 7'h3A, 8'h00, 8'hEE, 1'b0, 1'b1, "timeout");
        wait_idle("timeout");

        // req1 fields move while req0 is in service and again after req1 is
        // accepted; only the value present in IDLE may reach the master.
        push(0, 1'b0, 7'h0F, 8'h66, 8'h00, 1'b0, 1'b0);
        push(1, 1'b1, 7'h22, 8'h00, 8'h81, 1'b0, 1'b0);
        req0_rw = 1'b0; req0_addr = 7'h0F; req0_din = 8'h66; req0_valid = 1'b1;
        @(negedge clk);
        wait_ready(0, "change0");
        req0_valid = 1'b0;
        req1_rw = 1'b1; req1_addr = 7'h11; req1_din = 8'h00; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        req1_addr = 7'h22;
        wait_ready(1, "change1");
        req1_valid = 1'b0; req1_addr = 7'h77; req1_din = 8'hFF; req1_rw = 1'b0;
        wait_idle("change");

        // Reset during WAIT_DONE: no done pulse, bus released, then normal service.
        push(0, 1'b1, 7'h44, 8'h00, 8'h00, 1'b0, 1'b1);
        req0_rw = 1'b1; req0_addr = 7'h44; req0_din = 8'h00; req0_valid = 1'b1;
        @(negedge clk);
        wait_ready(0, "rstmid");
        req0_valid = 1'b0;
        k = 0;
        while (!m_busy && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) check("rstmid_busy_wait", 0, 1);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rstmid_gnt", gnt, 0);
        check("rstmid_dv", m_dataValid, 0);
        check("rstmid_done", {req1_done, req0_done}, 0);
        check("rstmid_timeout", timeout, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(1, 1'b0, 7'h2B, 8'hC3, 8'h00, 1'b0, 1'b0, "after_rst");
        wait_idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
